// File: rtl/game_timer.sv
// Game timer: a prescaled tick drives a total-count timer that runs up to LIMIT
// or down from LIMIT, with sec/min kept by incremental counters.
module game_timer #(
    parameter int CLK_HZ     = 50000000,
    parameter int TICK_HZ    = 1,
    parameter int TIMER_W    = 11,
    parameter int COUNT_DOWN = 0,
    parameter int LIMIT      = 2047
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               pause,
    input  logic               clear,
    output logic               tick,
    output logic [TIMER_W-1:0] timer,
    output logic [5:0]         sec,
    output logic [7:0]         min,
    output logic               running,
    output logic               done
);

    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int PRE_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int INIT  = (COUNT_DOWN != 0) ? LIMIT : 0;

    localparam logic [PRE_W-1:0]   PRE_MAX   = PRE_W'(DIV - 1);
    localparam logic [TIMER_W-1:0] LIMIT_T   = TIMER_W'(LIMIT);
    localparam logic [TIMER_W-1:0] INIT_T    = TIMER_W'(INIT);
    localparam logic [5:0]         INIT_SEC  = 6'(INIT % 60);
    localparam logic [TIMER_W-1:0] INIT_QUO  = TIMER_W'(INIT / 60);

    if (DIV < 2) begin : g_bad_div
        $error("game_timer: CLK_HZ/TICK_HZ must be at least 2");
    end
    if ((LIMIT < 1) || (longint'(LIMIT) > ((longint'(1) << TIMER_W) - 1))) begin : g_bad_limit
        $error("game_timer: LIMIT must lie in 1 .. 2^TIMER_W-1");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUNNING,
        ST_PAUSED,
        ST_DONE
    } state_t;

    state_t               state_reg, state_next;
    logic [PRE_W-1:0]     pre_reg, pre_next;
    logic [TIMER_W-1:0]   timer_reg, timer_next;
    logic [5:0]           sec_reg, sec_next;
    logic [TIMER_W-1:0]   quo_reg, quo_next;
    logic [7:0]           min_reg, min_next;
    logic                 tick_reg, tick_next;
    logic                 running_reg, running_next;
    logic                 done_reg, done_next;

    // Values one count step away from the current ones, for the configured direction.
    logic [TIMER_W-1:0]   step_timer;
    logic [5:0]           step_sec;
    logic [TIMER_W-1:0]   step_quo;
    logic                 step_last;
    logic                 wrap;

    // The full quotient is tracked so min stays correct when leaving saturation.
    function automatic logic [7:0] sat_min(input logic [TIMER_W-1:0] q);
        int unsigned qi;
        qi = 32'(q);
        return (qi > 255) ? 8'd255 : 8'(qi);
    endfunction

    if (COUNT_DOWN != 0) begin : g_down
        always_comb begin
            step_timer = timer_reg - 1'b1;
            step_last  = (timer_reg == TIMER_W'(1));
            if (sec_reg == 6'd0) begin
                step_sec = 6'd59;
                step_quo = quo_reg - 1'b1;
            end else begin
                step_sec = sec_reg - 1'b1;
                step_quo = quo_reg;
            end
        end
    end else begin : g_up
        always_comb begin
            step_timer = timer_reg + 1'b1;
            step_last  = (step_timer == LIMIT_T);
            if (sec_reg == 6'd59) begin
                step_sec = 6'd0;
                step_quo = quo_reg + 1'b1;
            end else begin
                step_sec = sec_reg + 1'b1;
                step_quo = quo_reg;
            end
        end
    end

    assign wrap = (state_reg == ST_RUNNING) && (pre_reg == PRE_MAX);

    always_comb begin
        state_next = state_reg;
        pre_next   = pre_reg;
        timer_next = timer_reg;
        sec_next   = sec_reg;
        quo_next   = quo_reg;
        tick_next  = 1'b0;

        if (clear) begin
            state_next = ST_IDLE;
            pre_next   = '0;
            timer_next = INIT_T;
            sec_next   = INIT_SEC;
            quo_next   = INIT_QUO;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) state_next = ST_RUNNING;
                end
                ST_RUNNING: begin
                    pre_next = wrap ? '0 : pre_reg + 1'b1;
                    if (pause) state_next = ST_PAUSED;
                    // A wrap still counts even when pause arrives in the same cycle.
                    if (wrap) begin
                        tick_next  = 1'b1;
                        timer_next = step_timer;
                        sec_next   = step_sec;
                        quo_next   = step_quo;
                        if (step_last) state_next = ST_DONE;
                    end
                end
                ST_PAUSED: begin
                    if (start) state_next = ST_RUNNING;
                end
                default: begin
                    state_next = ST_DONE;
                end
            endcase
        end

        running_next = (state_next == ST_RUNNING);
        done_next    = (state_next == ST_DONE);
        min_next     = sat_min(quo_next);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            pre_reg     <= '0;
            timer_reg   <= INIT_T;
            sec_reg     <= INIT_SEC;
            quo_reg     <= INIT_QUO;
            min_reg     <= sat_min(INIT_QUO);
            tick_reg    <= 1'b0;
            running_reg <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pre_reg     <= pre_next;
            timer_reg   <= timer_next;
            sec_reg     <= sec_next;
            quo_reg     <= quo_next;
            min_reg     <= min_next;
            tick_reg    <= tick_next;
            running_reg <= running_next;
            done_reg    <= done_next;
        end
    end

    assign tick    = tick_reg;
    assign timer   = timer_reg;
    assign sec     = sec_reg;
    assign min     = min_reg;
    assign running = running_reg;
    assign done    = done_reg;

endmodule
